// File: rtl/noc_pkg.sv
// Shared NoC address helpers and injection FSM state encoding.
// No latency (types and pure functions only).
// No flow control of its own.
package noc_pkg;

  localparam int ADDR_W  = 6;
  localparam int GRP_HI  = 5;
  localparam int GRP_LO  = 2;
  localparam int PORT_HI = 1;
  localparam int PORT_LO = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GAP  = 1'b1
  } inj_state_t;

  function automatic logic is_self_addr(
    input logic [ADDR_W-1:0]        dest,
    input logic [GRP_HI-GRP_LO:0]   group,
    input logic [PORT_HI-PORT_LO:0] port
  );
    return (dest[GRP_HI:GRP_LO] == group) && (dest[PORT_HI:PORT_LO] == port);
  endfunction

endpackage

// File: rtl/gpu_inject_queue_sync_fifo.sv
// Synchronous FIFO with registered storage; head readable combinationally.
// Latency: a push is visible at the head one cycle later (no bypass).
// Backpressure: push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == DEPTH_V);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/gpu_inject_queue.sv
// GPU-to-router injection queue: buffers flits, drops self-addressed ones, paces launches.
// Latency: push at edge k launches a one-cycle gpu_in_valid pulse at edge k+1; 1+GAP_CYCLES spacing.
// Backpressure: s_ready follows FIFO occupancy only; router grant gates pops via arb_enable/crossbar_busy.
module gpu_inject_queue
  import noc_pkg::*;
#(
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] GROUP_ID   = 4'b0110,
  parameter logic [1:0] LOCAL_PORT = 2'd3,
  parameter int         GAP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DWIDTH-1:0]             s_data,
  input  logic [ADDR_W-1:0]             s_dest,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          arb_enable,
  input  logic                          crossbar_busy,
  output logic [DWIDTH-1:0]             gpu_in_data,
  output logic [ADDR_W-1:0]             gpu_dest_addr,
  output logic                          gpu_in_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [7:0]                    drop_count
);

  localparam int              FW       = DWIDTH + ADDR_W;
  localparam int              GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0]   GAP_ONE  = GW'(1);

  inj_state_t          state;
  logic [GW-1:0]       gap_cnt;
  logic [FW-1:0]       head;
  logic [DWIDTH-1:0]   head_data;
  logic [ADDR_W-1:0]   head_dest;
  logic                head_self;
  logic                push;
  logic                pop;

  assign s_ready   = ~fifo_full & ~reset;
  assign push      = s_valid & s_ready;
  assign head_data = head[FW-1:ADDR_W];
  assign head_dest = head[ADDR_W-1:0];
  assign head_self = is_self_addr(head_dest, GROUP_ID, LOCAL_PORT);
  // Grant is sampled live in IDLE only; GAP ignores it entirely.
  assign pop       = (state == IDLE) & ~fifo_empty & arb_enable & ~crossbar_busy;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data ({s_data, s_dest}),
    .rd_data (head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      gpu_in_valid  <= 1'b0;
      gpu_in_data   <= '0;
      gpu_dest_addr <= '0;
      drop_count    <= '0;
    end else begin
      gpu_in_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            if (head_self) begin
              if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end else begin
              gpu_in_data   <= head_data;
              gpu_dest_addr <= head_dest;
              gpu_in_valid  <= 1'b1;
              gap_cnt       <= '0;
              state         <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_inject_queue.sv
// Scoreboard bench for gpu_inject_queue: expected launches queued at push time, checked on each pulse.
module tb_gpu_inject_queue;

  logic        clk;
  logic        reset;
  logic [15:0] s_data;
  logic [5:0]  s_dest;
  logic        s_valid;
  logic        s_ready;
  logic        arb_enable;
  logic        crossbar_busy;
  logic [15:0] gpu_in_data;
  logic [5:0]  gpu_dest_addr;
  logic        gpu_in_valid;
  logic [3:0]  fifo_level;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  drop_count;

  localparam logic [5:0] SELF = 6'b011011;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          pulse_cyc[$];
  logic [21:0] sb[$];

  gpu_inject_queue dut (
    .clk           (clk),
    .reset         (reset),
    .s_data        (s_data),
    .s_dest        (s_dest),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .arb_enable    (arb_enable),
    .crossbar_busy (crossbar_busy),
    .gpu_in_data   (gpu_in_data),
    .gpu_dest_addr (gpu_dest_addr),
    .gpu_in_valid  (gpu_in_valid),
    .fifo_level    (fifo_level),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .drop_count    (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: edge, then sample at the falling edge and score any launch pulse.
  task automatic tick();
    logic [21:0] exp;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (gpu_in_valid === 1'b1) begin
      pulses++;
      pulse_cyc.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got data=%h dest=%b, required no pulse", gpu_in_data, gpu_dest_addr);
      end else begin
        exp = sb.pop_front();
        if ({gpu_in_data, gpu_dest_addr} !== exp) begin
          errors++;
          $display("FAIL launch_flit: got data=%h dest=%b, required data=%h dest=%b",
                   gpu_in_data, gpu_dest_addr, exp[21:6], exp[5:0]);
        end
      end
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [5:0] a, output bit acc);
    s_data  = d;
    s_dest  = a;
    s_valid = 1'b1;
    acc     = s_ready;
    if (acc && a != SELF) sb.push_back({d, a});
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int n = 0; n < max_cycles && sb.size() > 0; n++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d flits still expected, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_dest = '0;
    arb_enable = 1'b0; crossbar_busy = 1'b0;
    tick(); tick();
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b, required 0", s_ready); end
    checks++;
    if ({gpu_in_valid, gpu_in_data, gpu_dest_addr} !== 23'd0) begin
      errors++; $display("FAIL reset_outputs: got v=%b d=%h a=%b, required all 0", gpu_in_valid, gpu_in_data, gpu_dest_addr);
    end
    checks++;
    if (drop_count !== 8'd0 || fifo_level !== 4'd0) begin
      errors++; $display("FAIL reset_counts: got drop=%0d level=%0d, required 0/0", drop_count, fifo_level);
    end
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got empty=%b full=%b, required 1/0", fifo_empty, fifo_full);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: got %b, required 1", s_ready); end
  endtask

  task automatic test_single();
    bit acc;
    int k;
    arb_enable = 1'b1; crossbar_busy = 1'b0;
    pulse_cyc.delete();
    push(16'hA5A5, 6'b000110, acc);
    k = cyc;
    checks++;
    if (!acc || fifo_level !== 4'd1 || gpu_in_valid !== 1'b0) begin
      errors++; $display("FAIL single_after_push: got acc=%0d level=%0d v=%b, required 1/1/0", acc, fifo_level, gpu_in_valid);
    end
    tick();
    checks++;
    if (pulse_cyc.size() != 1 || pulse_cyc[0] != k + 1) begin
      errors++; $display("FAIL single_latency: got %0d pulses (first at %0d), required 1 at %0d",
                         pulse_cyc.size(), (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1, k + 1);
    end
    checks++;
    if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_level: got %0d, required 0", fifo_level); end
    tick();
    checks++;
    if (gpu_in_valid !== 1'b0 || gpu_in_data !== 16'hA5A5 || gpu_dest_addr !== 6'b000110) begin
      errors++; $display("FAIL single_hold: got v=%b d=%h a=%b, required 0/a5a5/000110", gpu_in_valid, gpu_in_data, gpu_dest_addr);
    end
    tick(); tick();
  endtask

  task automatic test_fill();
    bit acc;
    arb_enable = 1'b0; crossbar_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(16'h1000 + 16'(i), {4'h1, 2'(i)}, acc);
      checks++;
      if (!acc) begin errors++; $display("FAIL fill_accept_%0d: got not accepted, required accepted", i); end
    end
    checks++;
    if (fifo_full !== 1'b1 || s_ready !== 1'b0 || fifo_level !== 4'd8) begin
      errors++; $display("FAIL fill_full: got full=%b rdy=%b level=%0d, required 1/0/8", fifo_full, s_ready, fifo_level);
    end
    push(16'hDEAD, 6'b000101, acc);
    checks++;
    if (acc || fifo_level !== 4'd8) begin
      errors++; $display("FAIL fill_ninth: got acc=%0d level=%0d, required 0/8", acc, fifo_level);
    end
    pulse_cyc.delete();
    arb_enable = 1'b1;
    drain(60);
    checks++;
    if (pulse_cyc.size() != 8) begin errors++; $display("FAIL fill_pulse_count: got %0d, required 8", pulse_cyc.size()); end
    for (int j = 1; j < pulse_cyc.size(); j++) begin
      checks++;
      if (pulse_cyc[j] - pulse_cyc[j-1] != 3) begin
        errors++; $display("FAIL fill_spacing_%0d: got %0d cycles, required 3", j, pulse_cyc[j] - pulse_cyc[j-1]);
      end
    end
    tick(); tick(); tick();
  endtask

  task automatic test_busy();
    bit acc;
    int base;
    int t0;
    arb_enable = 1'b1; crossbar_busy = 1'b1;
    push(16'hB001, 6'b100001, acc);
    push(16'hB002, 6'b110010, acc);
    base = pulses;
    repeat (10) tick();
    checks++;
    if (pulses != base || fifo_level !== 4'd2) begin
      errors++; $display("FAIL busy_hold: got %0d pulses level=%0d, required 0 pulses level=2", pulses - base, fifo_level);
    end
    pulse_cyc.delete();
    crossbar_busy = 1'b0;
    t0 = cyc;
    drain(20);
    checks++;
    if (pulse_cyc.size() != 2 || pulse_cyc[0] != t0 + 1 || pulse_cyc[1] != t0 + 4) begin
      errors++; $display("FAIL busy_release: got %0d pulses at +%0d/+%0d, required 2 at +1/+4", pulse_cyc.size(),
                         (pulse_cyc.size() > 0) ? pulse_cyc[0] - t0 : -1, (pulse_cyc.size() > 1) ? pulse_cyc[1] - t0 : -1);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_drop();
    bit acc;
    int base;
    int t0;
    arb_enable = 1'b0; crossbar_busy = 1'b0;
    push(16'h1111, SELF, acc);
    push(16'h2222, 6'b001000, acc);
    pulse_cyc.delete();
    base = pulses;
    arb_enable = 1'b1;
    t0 = cyc;
    tick();
    checks++;
    if (drop_count !== 8'd1 || gpu_in_valid !== 1'b0 || fifo_level !== 4'd1) begin
      errors++; $display("FAIL drop_first: got drop=%0d v=%b level=%0d, required 1/0/1", drop_count, gpu_in_valid, fifo_level);
    end
    tick();
    checks++;
    if (pulses != base + 1 || pulse_cyc.size() != 1 || pulse_cyc[0] != t0 + 2) begin
      errors++; $display("FAIL drop_next_launch: got %0d pulses, required 1 at cycle %0d", pulses - base, t0 + 2);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_saturation();
    bit acc;
    int base;
    arb_enable = 1'b1; crossbar_busy = 1'b0;
    base = pulses;
    for (int i = 0; i < 260; i++) push(16'(i), SELF, acc);
    tick(); tick(); tick();
    checks++;
    if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d, required 255", drop_count); end
    checks++;
    if (pulses != base || fifo_level !== 4'd0) begin
      errors++; $display("FAIL drop_no_pulse: got %0d pulses level=%0d, required 0/0", pulses - base, fifo_level);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    int base;
    arb_enable = 1'b0; crossbar_busy = 1'b0;
    for (int i = 0; i < 5; i++) push(16'hC000 + 16'(i), {4'h2, 2'(i)}, acc);
    arb_enable = 1'b1;
    tick();
    checks++;
    if (gpu_in_valid !== 1'b1 || fifo_level !== 4'd4) begin
      errors++; $display("FAIL rmid_launch: got v=%b level=%0d, required 1/4", gpu_in_valid, fifo_level);
    end
    sb.delete();
    reset = 1'b1;
    tick();
    checks++;
    if ({gpu_in_valid, gpu_in_data, gpu_dest_addr} !== 23'd0 || drop_count !== 8'd0) begin
      errors++; $display("FAIL rmid_outputs: got v=%b d=%h a=%b drop=%0d, required all 0",
                         gpu_in_valid, gpu_in_data, gpu_dest_addr, drop_count);
    end
    checks++;
    if (fifo_level !== 4'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_fifo: got level=%0d empty=%b full=%b rdy=%b, required 0/1/0/0",
                         fifo_level, fifo_empty, fifo_full, s_ready);
    end
    reset = 1'b0;
    base = pulses;
    repeat (10) tick();
    checks++;
    if (pulses != base) begin errors++; $display("FAIL rmid_quiet: got %0d pulses, required 0", pulses - base); end
    push(16'h7E57, 6'b111100, acc);
    drain(10);
    checks++;
    if (pulses != base + 1) begin errors++; $display("FAIL rmid_resume: got %0d pulses, required 1", pulses - base); end
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_busy();
    test_drop();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_inject_queue.md
# gpu_inject_queue

Upstream injection stage between a GPU client and the group-6 leaf router's GPU port. Buffers GPU flits with their 6-bit destinations in a FIFO and launches them one at a time as single-cycle `gpu_in_valid` pulses, only while the router grants access. Locally addressed flits are discarded. The router has no GPU-side ready, so the queue provides the backpressure and buffering the router itself lacks.

## Interface
- `DWIDTH`, 16, flit data width
- `FIFO_DEPTH`, 8, FIFO entries; power of two, ≥2
- `GROUP_ID`, 4'b0110, group field of this router's address
- `LOCAL_PORT`, 2'd3, port field of this router's own address
- `GAP_CYCLES`, 2, mandatory idle cycles after each launch; ≥1
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `s_data`  in  DWIDTH  GPU flit
- `s_dest`  in  6  GPU flit destination, {group[5:2], port[1:0]}
- `s_valid`  in  1  GPU offers a flit
- `s_ready`  out  1  queue accepts; transfer occurs when `s_valid & s_ready` at an edge
- `arb_enable`  in  1  router arbitration enable
- `crossbar_busy`  in  1  router crossbar busy
- `gpu_in_data`  out  DWIDTH  flit to router, registered
- `gpu_dest_addr`  out  6  destination to router, registered
- `gpu_in_valid`  out  1  one-cycle launch pulse, registered
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy
- `fifo_full`, `fifo_empty`  out  1  occupancy flags
- `drop_count`  out  8  saturating count of discarded self-addressed flits

## Operation
- FSM states:
  - IDLE: may pop.
  - GAP: counts `GAP_CYCLES` then returns to IDLE.
- Pop condition in IDLE: `!fifo_empty & arb_enable & !crossbar_busy`.
- Head is self-addressed (`dest == {GROUP_ID, LOCAL_PORT}`):
  - Pop and discard; no pulse.
  - `drop_count` += 1, saturating at 255.
  - Stay in IDLE, so the next head is eligible on the following cycle.
- Head is not self-addressed:
  - Pop and load `gpu_in_data`/`gpu_dest_addr`.
  - Assert `gpu_in_valid` for exactly one cycle; go to GAP.
- `gpu_in_data`/`gpu_dest_addr` hold their last launched values until the next launch.
- Pop conditions are not sampled in GAP, even if `crossbar_busy` drops early.
- `s_ready = !fifo_full & !reset`. It depends only on occupancy: a same-cycle pop does not open a slot for a push when full.
- Simultaneous push and pop when neither full nor empty: level unchanged, order preserved.
- Push into an empty FIFO is not bypassed; it is visible at the head one cycle later.
- FIFO is strictly in order: a self-addressed head is dropped only when it reaches the head.
- `arb_enable` or `crossbar_busy` changing during GAP has no effect until GAP ends.

## Timing
- Reset (synchronous) clears FIFO pointers, FSM to IDLE, and the GAP counter. Output values while reset is high or after release:
  - `gpu_in_valid` = 0, `gpu_in_data` = 0, `gpu_dest_addr` = 0
  - `drop_count` = 0, `fifo_level` = 0, `fifo_empty` = 1, `fifo_full` = 0
  - `s_ready` = 0 while reset is high, 1 the cycle after release
- Reset asserted mid-GAP or during a pulse: the pulse ends at that edge and queued flits are lost.
- Latency, with the FIFO empty and conditions true: push at edge k → pop at edge k+1 → `gpu_in_valid` high from edge k+1 to edge k+2.
- Back-to-back launch spacing is 1 + `GAP_CYCLES` cycles; with the default, one pulse every 3 cycles.
- `crossbar_busy` and `arb_enable` are sampled combinationally in IDLE; no registered lookahead.

## Structure
- Shared package `noc_pkg`:
  - `ADDR_W` = 6
  - address field slices (group [5:2], port [1:0])
  - FSM state enum {IDLE, GAP}
  - function `is_self_addr(dest, group, port)`
- Sub-module `sync_fifo`:
  - parameters: width `DWIDTH+6`, depth `FIFO_DEPTH`
  - ports: push, pop, data in/out, level, full, empty
  - registered memory
  - pointers one bit wider than the address for full/empty detection
- The top level holds the FSM, GAP counter, output registers and drop counter.

## Test plan
- **Single launch:** push {data 16'hA5A5, dest 6'b0001_10}; `arb_enable`=1, `busy`=0 → one-cycle pulse 2 edges later carrying A5A5/0001_10; level returns to 0.
- **Fill and backpressure:** `arb_enable`=0, push 9 flits → 8 accepted, `s_ready`=0 and `fifo_full`=1 after the 8th. Enable → 8 pulses, in order, spaced 3 cycles apart.
- **Busy hold-off:** `busy`=1 for 10 cycles with 2 flits queued → no pulse. `busy`→0 → first pulse in the next cycle, second pulse 3 cycles later.
- **Self-address drop:** queue dests 6'b0110_11, 6'b0010_00 → `drop_count`=1, exactly one pulse with dest 0010_00, one cycle after the drop.
- **Drop saturation:** 260 self-addressed flits → `drop_count` stays at 255, no pulses.
- **Reset mid-operation:** assert reset during GAP with 4 flits queued → next edge: all outputs at reset values, level 0; no pulse after release until a new push.
